bcd_mod_counter: RTL and testbench

Parametrised modulo-N BCD counter with 7-segment outputs, one stage of the clock time-base chain (seconds, minutes, hours, days, years, centuries).
Generalises the fixed single-digit counter: NDIG BCD digits, arbitrary modulus, up/down counting, synchronous load and a cascadable terminal-count output.
Stages are chained by feeding one stage's done into the next stage's enable.

---
 rtl/bcd_mod_counter.sv | 142 ++++++++++++++
 tb/tb_bcd_mod_counter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_mod_counter.sv
// Modulo-N BCD counter stage with cascade carry and 7-segment decode.
// Optional: define BLANK_LEADING_ZERO_EN to blank leading zero digits.
module bcd_mod_counter #(
  parameter int NDIG    = 2,
  parameter int MODULUS = 60
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              up,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_val,
  output logic [4*NDIG-1:0] count_bcd,
  output logic              done,
  output logic              load_err,
  output logic [7*NDIG-1:0] seg
);

  localparam int W = 4 * NDIG;

  function automatic logic [W-1:0] to_bcd(input int v);
    int t;
    t = v;
    to_bcd = '0;
    for (int k = 0; k < NDIG; k++) begin
      to_bcd[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    unique case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Top of range in BCD; valid BCD compares in numeric order as a vector.
  localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] inc, dec;
  logic         err_q, err_d;
  logic         dig_ok, lv_ok;
  logic         term;
  logic         cy, bw;

  // Load validity: every digit 0..9 and value below the modulus.
  always_comb begin
    dig_ok = 1'b1;
    for (int k = 0; k < NDIG; k++) begin
      if (load_val[4*k +: 4] > 4'd9) dig_ok = 1'b0;
    end
    lv_ok = dig_ok && (load_val <= MAX_BCD);
  end

  // Decimal ripple increment and decrement of the held count.
  always_comb begin
    inc = cnt_q;
    dec = cnt_q;
    cy  = 1'b1;
    bw  = 1'b1;
    for (int k = 0; k < NDIG; k++) begin
      if (cy) begin
        if (cnt_q[4*k +: 4] == 4'd9) begin
          inc[4*k +: 4] = 4'd0;
        end else begin
          inc[4*k +: 4] = cnt_q[4*k +: 4] + 4'd1;
          cy = 1'b0;
        end
      end
      if (bw) begin
        if (cnt_q[4*k +: 4] == 4'd0) begin
          dec[4*k +: 4] = 4'd9;
        end else begin
          dec[4*k +: 4] = cnt_q[4*k +: 4] - 4'd1;
          bw = 1'b0;
        end
      end
    end
  end

  assign term = up ? (cnt_q == MAX_BCD) : (cnt_q == '0);
  assign done = enable & ~load & term;

  // Next state: load beats step beats hold.
  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    unique case (1'b1)
      load: begin
        if (lv_ok) cnt_d = load_val;
        else       err_d = 1'b1;
      end
      (enable && !load): begin
        if (term) cnt_d = up ? '0 : MAX_BCD;
        else      cnt_d = up ? inc : dec;
      end
      default: ;
    endcase
  end

  // Count and load-error registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign count_bcd = cnt_q;
  assign load_err  = err_q;

  // Segment decode, scanning from the top digit to track leading zeros.
  always_comb begin
    logic nz;
    nz  = 1'b0;
    seg = '1;
    for (int k = NDIG - 1; k >= 0; k--) begin
      nz = nz | (cnt_q[4*k +: 4] != 4'd0);
`ifdef BLANK_LEADING_ZERO_EN
      if (k > 0 && !nz) seg[7*k +: 7] = 7'b1111111;
      else              seg[7*k +: 7] = seg7(cnt_q[4*k +: 4]);
`else
      seg[7*k +: 7] = seg7(cnt_q[4*k +: 4]);
`endif
    end
  end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Randomised and directed bench for bcd_mod_counter.
// Three stages: 60 chained into 24, plus a 3-digit modulo-250.
module tb_bcd_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        en_a, up_a, ld_a;
  logic [7:0]  lv_a, cnt_a;
  logic        done_a, err_a;
  logic [13:0] seg_a;
  logic        up_b, ld_b;
  logic [7:0]  lv_b, cnt_b;
  logic        done_b, err_b;
  logic [13:0] seg_b;
  logic        en_c, up_c, ld_c;
  logic [11:0] lv_c, cnt_c;
  logic        done_c, err_c;
  logic [20:0] seg_c;

  bcd_mod_counter #(.NDIG(2), .MODULUS(60)) u_a (
    .clk(clk), .reset_n(reset_n), .enable(en_a), .up(up_a),
    .load(ld_a), .load_val(lv_a), .count_bcd(cnt_a),
    .done(done_a), .load_err(err_a), .seg(seg_a));

  bcd_mod_counter #(.NDIG(2), .MODULUS(24)) u_b (
    .clk(clk), .reset_n(reset_n), .enable(done_a), .up(up_b),
    .load(ld_b), .load_val(lv_b), .count_bcd(cnt_b),
    .done(done_b), .load_err(err_b), .seg(seg_b));

  bcd_mod_counter #(.NDIG(3), .MODULUS(250)) u_c (
    .clk(clk), .reset_n(reset_n), .enable(en_c), .up(up_c),
    .load(ld_c), .load_val(lv_c), .count_bcd(cnt_c),
    .done(done_c), .load_err(err_c), .seg(seg_c));

  int checks = 0;
  int errors = 0;
  int nb_done = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer counts.
  int mods [3] = '{60, 24, 250};
  int ndg  [3] = '{2, 2, 3};
  int m_cnt[3];
  bit m_err[3];
  logic [6:0] segt [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic int pow10(input int k);
    int r;
    r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [31:0] bcd_of(input int v, input int n);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < n; k++)
      r = r | (32'((v / pow10(k)) % 10) << (4 * k));
    return r;
  endfunction

  function automatic logic [31:0] seg_of(input int v, input int n);
    logic [31:0] r;
    logic [6:0]  p;
    r = '0;
    for (int k = 0; k < n; k++) begin
      p = segt[(v / pow10(k)) % 10];
`ifdef BLANK_LEADING_ZERO_EN
      if (k > 0 && v < pow10(k)) p = 7'h7F;
`endif
      r = r | (32'(p) << (7 * k));
    end
    return r;
  endfunction

  function automatic bit m_done(input int i, input bit en,
                                input bit up, input bit ld);
    if (!en || ld) return 1'b0;
    return up ? (m_cnt[i] == mods[i] - 1) : (m_cnt[i] == 0);
  endfunction

  task automatic mstep(input int i, input bit en, input bit up,
                       input bit ld, input logic [31:0] lv);
    int v, d;
    bit ok;
    if (ld) begin
      ok = 1'b1;
      v  = 0;
      for (int k = 0; k < ndg[i]; k++) begin
        d = int'((lv >> (4 * k)) & 32'hF);
        if (d > 9) ok = 1'b0;
        v = v + d * pow10(k);
      end
      if (ok && v < mods[i]) begin
        m_cnt[i] = v;
        m_err[i] = 1'b0;
      end else begin
        m_err[i] = 1'b1;
      end
    end else begin
      m_err[i] = 1'b0;
      if (en)
        m_cnt[i] = up ? (m_cnt[i] + 1) % mods[i]
                      : (m_cnt[i] + mods[i] - 1) % mods[i];
    end
  endtask

  task automatic check_state();
    check("cnt_a", cnt_a, bcd_of(m_cnt[0], 2));
    check("cnt_b", cnt_b, bcd_of(m_cnt[1], 2));
    check("cnt_c", cnt_c, bcd_of(m_cnt[2], 3));
    check("err_a", err_a, m_err[0]);
    check("err_b", err_b, m_err[1]);
    check("err_c", err_c, m_err[2]);
    check("seg_a", seg_a, seg_of(m_cnt[0], 2));
    check("seg_b", seg_b, seg_of(m_cnt[1], 2));
    check("seg_c", seg_c, seg_of(m_cnt[2], 3));
  endtask

  always @(posedge clk) if (reset_n && done_b) nb_done++;

  // Called at posedge+1 with inputs already driven.
  task automatic tick();
    bit da, db, dc;
    #3;
    da = m_done(0, en_a, up_a, ld_a);
    db = m_done(1, da, up_b, ld_b);
    dc = m_done(2, en_c, up_c, ld_c);
    check("done_a", done_a, da);
    check("done_b", done_b, db);
    check("done_c", done_c, dc);
    @(posedge clk);
    mstep(0, en_a, up_a, ld_a, 32'(lv_a));
    mstep(1, da, up_b, ld_b, 32'(lv_b));
    mstep(2, en_c, up_c, ld_c, 32'(lv_c));
    #1;
    check_state();
  endtask

  task automatic idle();
    en_a = 0; ld_a = 0; ld_b = 0; en_c = 0; ld_c = 0;
    up_a = 1; up_b = 1; up_c = 1;
  endtask

  // Asynchronous reset applied between edges, at posedge+1.
  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_err[i] = 1'b0;
    end
    check_state();
    idle();
    #1;
    check("rst_done_a", done_a, 1'b0);
    check("rst_done_c", done_c, 1'b0);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    nb_done = 0;
    check_state();
  endtask

  initial begin
    lv_a = '0; lv_b = '0; lv_c = '0;
    idle();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Full upward run through the wrap.
    en_a = 1; up_a = 1;
    repeat (60) tick();
    check("wrap_b_once", nb_done, 0);
    check("cnt_b_after60", cnt_b, 8'h01);

    // Downward from 00 wraps to 59 then 58.
    up_a = 0;
    repeat (3) tick();

    // Direction change at a terminal value re-evaluates done at once.
    en_a = 0; ld_a = 1; lv_a = 8'h00;
    tick();
    ld_a = 0; en_a = 1; up_a = 0;
    #3;
    check("dn_term_done", done_a, m_done(0, 1, 0, 0));
    up_a = 1;
    #1;
    check("up_flip_done", done_a, m_done(0, 1, 1, 0));
    en_a = 0;
    tick();

    // Valid and rejected loads.
    ld_a = 1;
    lv_a = 8'h45; tick();
    lv_a = 8'h60; tick();
    lv_a = 8'h3A; tick();
    ld_a = 0;     tick();

    // Load wins over an enabled step at 59.
    ld_a = 1; lv_a = 8'h59; tick();
    en_a = 1; up_a = 1; lv_a = 8'h12; tick();
    ld_a = 0; en_a = 0;

    // Chained 60 x 24 run over a full day of ticks.
    do_reset();
    en_a = 1; up_a = 1; up_b = 1;
    repeat (1440) tick();
    check("day_b_done", nb_done, 1);
    check("day_a", cnt_a, 8'h00);
    check("day_b", cnt_b, 8'h00);
    repeat (75) tick();
    do_reset();

    // Three-digit carries, wraps and rejected loads.
    en_c = 1; up_c = 1;
    repeat (12) tick();
    ld_c = 1; lv_c = 12'h099; tick();
    ld_c = 0; tick();
    ld_c = 1; lv_c = 12'h249; tick();
    ld_c = 0; tick();
    up_c = 0; repeat (2) tick();
    ld_c = 1; lv_c = 12'h250; tick();
    lv_c = 12'h0A0; tick();
    lv_c = 12'h007; en_c = 0; tick();
    ld_c = 0; tick();
    check("seg_c_007", seg_c, seg_of(7, 3));

    // Random mix on all stages.
    for (int n = 0; n < 600; n++) begin
      en_a = ($urandom_range(0, 3) != 0);
      up_a = ($urandom_range(0, 4) != 0);
      ld_a = ($urandom_range(0, 9) == 0);
      lv_a = $urandom_range(0, 1) ? 8'(bcd_of($urandom_range(0, 59), 2))
                                  : 8'($urandom);
      up_b = $urandom_range(0, 1);
      ld_b = ($urandom_range(0, 19) == 0);
      lv_b = $urandom_range(0, 1) ? 8'(bcd_of($urandom_range(0, 23), 2))
                                  : 8'($urandom);
      en_c = $urandom_range(0, 1);
      up_c = $urandom_range(0, 1);
      ld_c = ($urandom_range(0, 9) == 0);
      lv_c = $urandom_range(0, 1) ? 12'(bcd_of($urandom_range(0, 249), 3))
                                  : 12'($urandom);
      tick();
      if (n == 300) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
